vx_mem_req_arb: RTL and testbench

Sits directly downstream of the core's dcache request channels and upstream of the L1 data cache port. Merges NUM_REQS core-side memory request channels onto one cache-side port using round-robin arbitration, and appends the source index to the request tag. Routes each cache response back to its originating channel using that index. Bounds outstanding reads with a credit counter and adds one register stage on each direction.

---
 rtl/vx_mem_arb_pkg.sv | 37 +++
 rtl/vx_mem_req_arb_rr.sv | 51 +++++
 rtl/vx_mem_req_arb.sv | 216 +++++++++++++++++++++
 tb/tb_vx_mem_req_arb.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_mem_arb_pkg.sv
// Shared types and width helpers for the vx_mem_req_arb slice.
// The default-width req_t/rsp_t record the field order used by the arbiter's internal registers.
package vx_mem_arb_pkg;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_kind_e;

  localparam int unsigned DEF_NUM_REQS   = 4;
  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam int unsigned DEF_DATA_SIZE  = 4;
  localparam int unsigned DEF_TAG_WIDTH  = 8;

  function automatic int unsigned calc_sel_bits(input int unsigned num_reqs);
    return (num_reqs > 1) ? $clog2(num_reqs) : 1;
  endfunction

  function automatic int unsigned calc_out_tag_width(input int unsigned tag_width,
                                                     input int unsigned num_reqs);
    return tag_width + calc_sel_bits(num_reqs);
  endfunction

  typedef struct packed {
    logic                                  rw;
    logic [DEF_ADDR_WIDTH-1:0]             addr;
    logic [DEF_DATA_SIZE-1:0]              byteen;
    logic [8*DEF_DATA_SIZE-1:0]            data;
    logic [DEF_TAG_WIDTH+2-1:0]            tag;
  } req_t;

  typedef struct packed {
    logic [8*DEF_DATA_SIZE-1:0]            data;
    logic [DEF_TAG_WIDTH-1:0]              tag;
  } rsp_t;

endpackage

// File: rtl/vx_mem_req_arb_rr.sv
// vx_rr_arbiter: round-robin arbiter holding its own pointer.
// The first requester at or after the pointer wins; the pointer advances past the winner.
module vx_rr_arbiter
  import vx_mem_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQS = 4,
  localparam int unsigned SEL_BITS = calc_sel_bits(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] req_mask,
  input  logic                advance,
  output logic [NUM_REQS-1:0] grant,
  output logic [SEL_BITS-1:0] grant_idx,
  output logic                grant_valid
);

  logic [SEL_BITS-1:0] rr_ptr;
  logic                found;

  // Two ordered passes (pointer..top, then 0..pointer-1) give the wrap-around priority.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      if (!found && req_mask[i] && (i >= 32'(rr_ptr))) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = SEL_BITS'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      if (!found && req_mask[i] && (i < 32'(rr_ptr))) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = SEL_BITS'(i);
      end
    end
    grant_valid = found;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (advance && grant_valid) begin
      rr_ptr <= (32'(grant_idx) == NUM_REQS - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/vx_mem_req_arb.sv
// Merges NUM_REQS dcache request channels onto one cache port with credit-limited reads,
// and routes responses back by tag index. Optional counters: define VX_MEM_ARB_PERF_EN.
module vx_mem_req_arb
  import vx_mem_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQS      = 4,
  parameter  int unsigned ADDR_WIDTH    = 32,
  parameter  int unsigned DATA_SIZE     = 4,
  parameter  int unsigned TAG_WIDTH     = 8,
  parameter  int unsigned MAX_PENDING   = 16,
  localparam int unsigned DATA_WIDTH    = 8 * DATA_SIZE,
  localparam int unsigned SEL_BITS      = calc_sel_bits(NUM_REQS),
  localparam int unsigned OUT_TAG_WIDTH = calc_out_tag_width(TAG_WIDTH, NUM_REQS),
  localparam int unsigned CNT_W         = $clog2(MAX_PENDING + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQS-1:0]            in_req_valid,
  input  logic [NUM_REQS-1:0]            in_req_rw,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0] in_req_addr,
  input  logic [NUM_REQS*DATA_SIZE-1:0]  in_req_byteen,
  input  logic [NUM_REQS*DATA_WIDTH-1:0] in_req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]  in_req_tag,
  output logic [NUM_REQS-1:0]            in_req_ready,
  output logic                           out_req_valid,
  output logic                           out_req_rw,
  output logic [ADDR_WIDTH-1:0]          out_req_addr,
  output logic [DATA_SIZE-1:0]           out_req_byteen,
  output logic [DATA_WIDTH-1:0]          out_req_data,
  output logic [OUT_TAG_WIDTH-1:0]       out_req_tag,
  input  logic                           out_req_ready,
  input  logic                           in_rsp_valid,
  input  logic [DATA_WIDTH-1:0]          in_rsp_data,
  input  logic [OUT_TAG_WIDTH-1:0]       in_rsp_tag,
  output logic                           in_rsp_ready,
  output logic [NUM_REQS-1:0]            out_rsp_valid,
  output logic [DATA_WIDTH-1:0]          out_rsp_data,
  output logic [TAG_WIDTH-1:0]           out_rsp_tag,
  input  logic [NUM_REQS-1:0]            out_rsp_ready,
  output logic [CNT_W-1:0]               pending_cnt
`ifdef VX_MEM_ARB_PERF_EN
  ,
  output logic [NUM_REQS*32-1:0]         perf_grants,
  output logic [31:0]                    perf_stall_cycles,
  output logic [31:0]                    perf_credit_stall
`endif
);

  typedef struct packed {
    logic                     rw;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [DATA_SIZE-1:0]     byteen;
    logic [DATA_WIDTH-1:0]    data;
    logic [OUT_TAG_WIDTH-1:0] tag;
  } arb_req_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;
  } arb_rsp_t;

  logic [NUM_REQS-1:0] eligible;
  logic [NUM_REQS-1:0] grant;
  logic [SEL_BITS-1:0] grant_idx;
  logic                grant_valid;
  logic                credit_full;
  logic                stage_load;
  logic                req_fire;
  logic                rd_fire;
  logic                rsp_fire;
  arb_req_t            mux_req;
  arb_req_t            req_r;
  arb_rsp_t            rsp_r;
  logic                rsp_valid_r;
  logic [SEL_BITS-1:0] sel_r;
  logic [SEL_BITS-1:0] in_rsp_sel;
  logic                sel_ready;

  // Writes bypass the credit check; only reads consume a credit.
  assign credit_full = (pending_cnt >= CNT_W'(MAX_PENDING));
  assign eligible    = in_req_valid & (in_req_rw | {NUM_REQS{~credit_full}});

  vx_rr_arbiter #(
    .NUM_REQS (NUM_REQS)
  ) u_rr_arbiter (
    .clk         (clk),
    .reset       (reset),
    .req_mask    (eligible),
    .advance     (stage_load),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign stage_load   = ~out_req_valid | out_req_ready;
  assign in_req_ready = grant & {NUM_REQS{stage_load}};
  assign req_fire     = grant_valid & stage_load;
  assign rd_fire      = req_fire & (mux_req.rw == REQ_READ);

  always_comb begin
    mux_req = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      if (grant[i]) begin
        mux_req.rw     = in_req_rw[i];
        mux_req.addr   = in_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        mux_req.byteen = in_req_byteen[i*DATA_SIZE +: DATA_SIZE];
        mux_req.data   = in_req_data[i*DATA_WIDTH +: DATA_WIDTH];
        mux_req.tag    = {in_req_tag[i*TAG_WIDTH +: TAG_WIDTH], SEL_BITS'(i)};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_req_valid <= 1'b0;
      req_r         <= '0;
    end else if (stage_load) begin
      out_req_valid <= req_fire;
      if (req_fire) begin
        req_r <= mux_req;
      end
    end
  end

  assign out_req_rw     = req_r.rw;
  assign out_req_addr   = req_r.addr;
  assign out_req_byteen = req_r.byteen;
  assign out_req_data   = req_r.data;
  assign out_req_tag    = req_r.tag;

  assign rsp_fire = in_rsp_valid & in_rsp_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_cnt <= '0;
    end else if (rd_fire && !rsp_fire) begin
      pending_cnt <= pending_cnt + 1'b1;
    end else if (!rd_fire && rsp_fire && (pending_cnt != '0)) begin
      pending_cnt <= pending_cnt - 1'b1;
    end
  end

  assign in_rsp_sel = in_rsp_tag[SEL_BITS-1:0];

  // An out-of-range sel matches no channel, so sel_ready stays 1 and the entry drains next cycle.
  always_comb begin
    sel_ready     = 1'b1;
    out_rsp_valid = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      if (sel_r == SEL_BITS'(i)) begin
        sel_ready        = out_rsp_ready[i];
        out_rsp_valid[i] = rsp_valid_r;
      end
    end
  end

  assign in_rsp_ready = ~rsp_valid_r | sel_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_r <= 1'b0;
      rsp_r       <= '0;
      sel_r       <= '0;
    end else if (in_rsp_ready) begin
      rsp_valid_r <= in_rsp_valid;
      if (in_rsp_valid) begin
        rsp_r.data <= in_rsp_data;
        rsp_r.tag  <= in_rsp_tag[OUT_TAG_WIDTH-1:SEL_BITS];
        sel_r      <= in_rsp_sel;
      end
    end
  end

  assign out_rsp_data = rsp_r.data;
  assign out_rsp_tag  = rsp_r.tag;

  a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
    !(rsp_fire && !rd_fire && (pending_cnt == '0)));

  a_rsp_sel_range: assert property (@(posedge clk) disable iff (!reset)
    !(rsp_fire && (32'(in_rsp_sel) >= NUM_REQS)));

`ifdef VX_MEM_ARB_PERF_EN
  logic [31:0] grant_cnt [NUM_REQS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REQS; i++) begin
        grant_cnt[i] <= '0;
      end
      perf_stall_cycles <= '0;
      perf_credit_stall <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQS; i++) begin
        if (in_req_ready[i]) begin
          grant_cnt[i] <= grant_cnt[i] + 32'd1;
        end
      end
      if (out_req_valid && !out_req_ready) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
      if (credit_full && (|(in_req_valid & ~in_req_rw))) begin
        perf_credit_stall <= perf_credit_stall + 32'd1;
      end
    end
  end

  always_comb begin
    perf_grants = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      perf_grants[i*32 +: 32] = grant_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_vx_mem_req_arb.sv
// Directed self-checking bench for vx_mem_req_arb (NUM_REQS=4, MAX_PENDING=4).
module tb_vx_mem_req_arb;

  localparam int unsigned N   = 4;
  localparam int unsigned AW  = 32;
  localparam int unsigned DS  = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned TW  = 8;
  localparam int unsigned MP  = 4;
  localparam int unsigned OTW = 10;
  localparam int unsigned CW  = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    in_req_valid;
  logic [N-1:0]    in_req_rw;
  logic [N*AW-1:0] in_req_addr;
  logic [N*DS-1:0] in_req_byteen;
  logic [N*DW-1:0] in_req_data;
  logic [N*TW-1:0] in_req_tag;
  logic [N-1:0]    in_req_ready;
  logic            out_req_valid;
  logic            out_req_rw;
  logic [AW-1:0]   out_req_addr;
  logic [DS-1:0]   out_req_byteen;
  logic [DW-1:0]   out_req_data;
  logic [OTW-1:0]  out_req_tag;
  logic            out_req_ready;
  logic            in_rsp_valid;
  logic [DW-1:0]   in_rsp_data;
  logic [OTW-1:0]  in_rsp_tag;
  logic            in_rsp_ready;
  logic [N-1:0]    out_rsp_valid;
  logic [DW-1:0]   out_rsp_data;
  logic [TW-1:0]   out_rsp_tag;
  logic [N-1:0]    out_rsp_ready;
  logic [CW-1:0]   pending_cnt;
`ifdef VX_MEM_ARB_PERF_EN
  logic [N*32-1:0] perf_grants;
  logic [31:0]     perf_stall_cycles;
  logic [31:0]     perf_credit_stall;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;
  int          exp_seq [6] = '{0, 1, 3, 0, 1, 3};
  int          grant_hist [4] = '{0, 0, 0, 0};

  vx_mem_req_arb #(
    .NUM_REQS    (N),
    .ADDR_WIDTH  (AW),
    .DATA_SIZE   (DS),
    .TAG_WIDTH   (TW),
    .MAX_PENDING (MP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_req_valid   (in_req_valid),
    .in_req_rw      (in_req_rw),
    .in_req_addr    (in_req_addr),
    .in_req_byteen  (in_req_byteen),
    .in_req_data    (in_req_data),
    .in_req_tag     (in_req_tag),
    .in_req_ready   (in_req_ready),
    .out_req_valid  (out_req_valid),
    .out_req_rw     (out_req_rw),
    .out_req_addr   (out_req_addr),
    .out_req_byteen (out_req_byteen),
    .out_req_data   (out_req_data),
    .out_req_tag    (out_req_tag),
    .out_req_ready  (out_req_ready),
    .in_rsp_valid   (in_rsp_valid),
    .in_rsp_data    (in_rsp_data),
    .in_rsp_tag     (in_rsp_tag),
    .in_rsp_ready   (in_rsp_ready),
    .out_rsp_valid  (out_rsp_valid),
    .out_rsp_data   (out_rsp_data),
    .out_rsp_tag    (out_rsp_tag),
    .out_rsp_ready  (out_rsp_ready),
    .pending_cnt    (pending_cnt)
`ifdef VX_MEM_ARB_PERF_EN
    ,
    .perf_grants       (perf_grants),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_credit_stall (perf_credit_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int ch, input logic v, input logic rw,
                           input logic [31:0] addr, input logic [7:0] tag);
    in_req_valid[ch]          = v;
    in_req_rw[ch]             = rw;
    in_req_addr[ch*AW +: AW]  = addr;
    in_req_tag[ch*TW +: TW]   = tag;
    in_req_data[ch*DW +: DW]  = addr ^ 32'hA5A5_0000;
    in_req_byteen[ch*DS +: DS] = 4'hF;
  endtask

  initial begin
    in_req_valid  = '0;
    in_req_rw     = '0;
    in_req_addr   = '0;
    in_req_byteen = '0;
    in_req_data   = '0;
    in_req_tag    = '0;
    out_req_ready = 1'b1;
    in_rsp_valid  = 1'b0;
    in_rsp_data   = '0;
    in_rsp_tag    = '0;
    out_rsp_ready = '1;

    // Reset state
    tick();
    tick();
    chk("rst_out_req_valid", 64'(out_req_valid), 64'd0);
    chk("rst_pending", 64'(pending_cnt), 64'd0);
    chk("rst_out_rsp_valid", 64'(out_rsp_valid), 64'd0);
    reset = 1'b1;
    tick();

    // Single read from ch2, then its response
    drive_req(2, 1'b1, 1'b0, 32'h100, 8'h5A);
    #1;
    chk("t1_in_req_ready", 64'(in_req_ready), 64'b0100);
    tick();
    drive_req(2, 1'b0, 1'b0, 32'h100, 8'h5A);
    chk("t1_out_valid", 64'(out_req_valid), 64'd1);
    chk("t1_out_tag", 64'(out_req_tag), 64'h16A);
    chk("t1_out_addr", 64'(out_req_addr), 64'h100);
    chk("t1_out_rw", 64'(out_req_rw), 64'd0);
    chk("t1_out_data", 64'(out_req_data), 64'hA5A5_0100);
    chk("t1_pending", 64'(pending_cnt), 64'd1);
    tick();
    chk("t1_out_drained", 64'(out_req_valid), 64'd0);
    in_rsp_valid = 1'b1;
    in_rsp_tag   = 10'h16A;
    in_rsp_data  = 32'hDEAD_BEEF;
    #1;
    chk("t1_in_rsp_ready", 64'(in_rsp_ready), 64'd1);
    tick();
    in_rsp_valid = 1'b0;
    chk("t1_rsp_valid", 64'(out_rsp_valid), 64'b0100);
    chk("t1_rsp_tag", 64'(out_rsp_tag), 64'h5A);
    chk("t1_rsp_data", 64'(out_rsp_data), 64'hDEAD_BEEF);
    chk("t1_pending_after_rsp", 64'(pending_cnt), 64'd0);
    tick();
    chk("t1_rsp_drained", 64'(out_rsp_valid), 64'd0);

    // Round-robin over channels 0,1,3 starting from a fresh pointer
    reset = 1'b0;
    #1;
    reset = 1'b1;
    drive_req(0, 1'b1, 1'b1, 32'h10, 8'h10);
    drive_req(1, 1'b1, 1'b1, 32'h11, 8'h11);
    drive_req(3, 1'b1, 1'b1, 32'h13, 8'h13);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("t2_grant%0d", k), 64'(out_req_tag[1:0]), 64'(exp_seq[k]));
      grant_hist[out_req_tag[1:0]]++;
    end
    drive_req(0, 1'b0, 1'b1, 32'h10, 8'h10);
    drive_req(1, 1'b0, 1'b1, 32'h11, 8'h11);
    drive_req(3, 1'b0, 1'b1, 32'h13, 8'h13);
    chk("t2_share_ch0", 64'(grant_hist[0]), 64'd2);
    chk("t2_share_ch1", 64'(grant_hist[1]), 64'd2);
    chk("t2_share_ch3", 64'(grant_hist[3]), 64'd2);
    chk("t2_writes_no_credit", 64'(pending_cnt), 64'd0);
    tick();
    chk("t2_drained", 64'(out_req_valid), 64'd0);

    // Back-pressure: output held stable while out_req_ready=0
    out_req_ready = 1'b0;
    drive_req(0, 1'b1, 1'b0, 32'h200, 8'h11);
    drive_req(1, 1'b1, 1'b0, 32'h300, 8'h22);
    tick();
    chk("t3_loaded_valid", 64'(out_req_valid), 64'd1);
    chk("t3_loaded_tag", 64'(out_req_tag), 64'h044);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("t3_hold_addr%0d", k), 64'(out_req_addr), 64'h200);
      chk($sformatf("t3_hold_tag%0d", k), 64'(out_req_tag), 64'h044);
      chk($sformatf("t3_hold_data%0d", k), 64'(out_req_data), 64'hA5A5_0200);
      chk($sformatf("t3_in_ready%0d", k), 64'(in_req_ready), 64'd0);
      chk($sformatf("t3_pending%0d", k), 64'(pending_cnt), 64'd1);
    end
    out_req_ready = 1'b1;
    drive_req(0, 1'b0, 1'b0, 32'h200, 8'h11);
    drive_req(1, 1'b0, 1'b0, 32'h300, 8'h22);
    tick();
    chk("t3_drained", 64'(out_req_valid), 64'd0);

    // Credit limit: reads block at MAX_PENDING, writes still pass
    drive_req(0, 1'b1, 1'b0, 32'h400, 8'h20);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t4_fill%0d", k), 64'(pending_cnt), 64'(k + 2));
    end
    #1;
    chk("t4_read_blocked", 64'(in_req_ready), 64'd0);
    drive_req(3, 1'b1, 1'b1, 32'h500, 8'h33);
    #1;
    chk("t4_write_allowed", 64'(in_req_ready), 64'b1000);
    tick();
    drive_req(3, 1'b0, 1'b1, 32'h500, 8'h33);
    chk("t4_write_tag", 64'(out_req_tag), 64'h0CF);
    chk("t4_write_rw", 64'(out_req_rw), 64'd1);
    chk("t4_pending_full", 64'(pending_cnt), 64'd4);
    #1;
    chk("t4_still_blocked", 64'(in_req_ready), 64'd0);
    tick();
    chk("t4_idle_out", 64'(out_req_valid), 64'd0);
    chk("t4_pending_hold", 64'(pending_cnt), 64'd4);
    in_rsp_valid = 1'b1;
    in_rsp_tag   = 10'h080;
    in_rsp_data  = 32'hCAFE_0000;
    tick();
    in_rsp_valid = 1'b0;
    chk("t4_rsp_pending", 64'(pending_cnt), 64'd3);
    chk("t4_rsp_valid", 64'(out_rsp_valid), 64'b0001);
    chk("t4_rsp_tag", 64'(out_rsp_tag), 64'h20);
    #1;
    chk("t4_unblocked", 64'(in_req_ready), 64'b0001);
    tick();
    drive_req(0, 1'b0, 1'b0, 32'h400, 8'h20);
    chk("t4_refill", 64'(pending_cnt), 64'd4);
    chk("t4_refill_tag", 64'(out_req_tag), 64'h080);

    // Response back-pressure on ch1
    out_rsp_ready = 4'b1101;
    in_rsp_valid  = 1'b1;
    in_rsp_tag    = 10'h0CD;
    in_rsp_data   = 32'h1234_5678;
    tick();
    chk("t5_rsp_valid", 64'(out_rsp_valid), 64'b0010);
    chk("t5_pending", 64'(pending_cnt), 64'd3);
    in_rsp_tag  = 10'h112;
    in_rsp_data = 32'hAAAA_5555;
    #1;
    chk("t5_in_rsp_blocked", 64'(in_rsp_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t5_hold_valid%0d", k), 64'(out_rsp_valid), 64'b0010);
      chk($sformatf("t5_hold_data%0d", k), 64'(out_rsp_data), 64'h1234_5678);
      chk($sformatf("t5_hold_tag%0d", k), 64'(out_rsp_tag), 64'h33);
      chk($sformatf("t5_hold_ready%0d", k), 64'(in_rsp_ready), 64'd0);
      chk($sformatf("t5_hold_pending%0d", k), 64'(pending_cnt), 64'd3);
    end
    out_rsp_ready = '1;
    #1;
    chk("t5_released", 64'(in_rsp_ready), 64'd1);
    tick();
    in_rsp_valid = 1'b0;
    chk("t5_next_valid", 64'(out_rsp_valid), 64'b0100);
    chk("t5_next_tag", 64'(out_rsp_tag), 64'h44);
    chk("t5_next_data", 64'(out_rsp_data), 64'hAAAA_5555);
    chk("t5_next_pending", 64'(pending_cnt), 64'd2);
    tick();
    chk("t5_drained", 64'(out_rsp_valid), 64'd0);

    // Asynchronous reset mid-transfer
    out_req_ready = 1'b0;
    drive_req(2, 1'b1, 1'b0, 32'h600, 8'h66);
    tick();
    drive_req(2, 1'b0, 1'b0, 32'h600, 8'h66);
    chk("t6_pre_valid", 64'(out_req_valid), 64'd1);
    chk("t6_pre_tag", 64'(out_req_tag), 64'h19A);
    chk("t6_pre_pending", 64'(pending_cnt), 64'd3);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_valid", 64'(out_req_valid), 64'd0);
    chk("t6_async_pending", 64'(pending_cnt), 64'd0);
    chk("t6_async_tag", 64'(out_req_tag), 64'd0);
    chk("t6_async_addr", 64'(out_req_addr), 64'd0);
    chk("t6_async_rsp", 64'(out_rsp_valid), 64'd0);
    #2;
    reset = 1'b1;
    out_req_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive_req(c, 1'b1, 1'b1, 32'h700 + 32'(c), 8'h70 + 8'(c));
    end
    #1;
    chk("t6_first_ready", 64'(in_req_ready), 64'b0001);
    tick();
    chk("t6_first_grant", 64'(out_req_tag), 64'h1C0);
    in_req_valid = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
